// File: rtl/buffer_pkg.sv
// Shared constants and FSM encoding for the circular-buffer offset counters.
package buffer_pkg;
  localparam int OFFSET_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;
endpackage

// File: rtl/buffer_read_offset_if.sv
// Control/status bundle between the read-offset tracker and its consumer/writer side.
interface buffer_read_offset_if;
  import buffer_pkg::*;

  logic                load_size;
  logic [OFFSET_W-1:0] size_in;
  logic                wr_inc;
  logic                rd_ready;
  logic                flush;
  logic [OFFSET_W-1:0] rd_offset;
  logic                rd_valid;
  logic [OFFSET_W-1:0] occupancy;
  logic                empty;
  logic                full;
  logic                overflow_err;

  modport master (
    output load_size, size_in, wr_inc, rd_ready, flush,
    input  rd_offset, rd_valid, occupancy, empty, full, overflow_err
  );

  modport slave (
    input  load_size, size_in, wr_inc, rd_ready, flush,
    output rd_offset, rd_valid, occupancy, empty, full, overflow_err
  );
endinterface

// File: rtl/offset_wrap_inc.sv
// Combinational wrap-around increment over 0..size-1; shared by reader and writer offsets.
// Callers keep offset < size, so offset + 1 cannot overflow 32 bits.
module offset_wrap_inc
  import buffer_pkg::*;
(
  input  logic [OFFSET_W-1:0] offset,
  input  logic [OFFSET_W-1:0] size,
  output logic [OFFSET_W-1:0] next_offset
);
  logic [OFFSET_W-1:0] inc;

  assign inc         = offset + {{(OFFSET_W-1){1'b0}}, 1'b1};
  assign next_offset = (inc >= size) ? '0 : inc;
endmodule

// File: rtl/buffer_read_offset.sv
// Read-side offset and occupancy tracker for a circular buffer; reads advance rd_offset in 1 cycle.
// rd_valid is registered-only; a write while full without a same-cycle read latches overflow_err.
module buffer_read_offset
  import buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  buffer_read_offset_if.slave  bus
);
  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] size_q, size_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [OFFSET_W-1:0] occ_q, occ_d;
  logic                err_q, err_d;
  logic [OFFSET_W-1:0] off_next;
  logic                rd_valid_w;
  logic                full_w;
  logic                rd_acc;

  offset_wrap_inc u_rd_wrap (
    .offset      (off_q),
    .size        (size_q),
    .next_offset (off_next)
  );

  assign rd_valid_w = (state_q == RUN) && (occ_q != '0);
  assign full_w     = (size_q != '0) && (occ_q == size_q);
  assign rd_acc     = rd_valid_w && bus.rd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      off_q   <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    occ_d   = occ_q;
    err_d   = err_q;

    if (bus.load_size) begin
      size_d  = bus.size_in;
      off_d   = '0;
      occ_d   = '0;
      err_d   = 1'b0;
      state_d = (bus.size_in != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (bus.flush) begin
            off_d = '0;
            occ_d = '0;
            err_d = 1'b0;
          end else if (bus.wr_inc && full_w && !rd_acc) begin
            // Occupancy stays pinned at size; only flush or load_size recovers.
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            if (rd_acc) off_d = off_next;
            if (bus.wr_inc && !rd_acc)      occ_d = occ_q + 32'd1;
            else if (rd_acc && !bus.wr_inc) occ_d = occ_q - 32'd1;
          end
        end
        ERROR: begin
          if (bus.flush) begin
            off_d   = '0;
            occ_d   = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rd_offset    = off_q;
  assign bus.rd_valid     = rd_valid_w;
  assign bus.occupancy    = occ_q;
  assign bus.empty        = (occ_q == '0);
  assign bus.full         = full_w;
  assign bus.overflow_err = err_q;
endmodule

// File: tb/tb_buffer_read_offset.sv
// Directed scenarios for buffer_read_offset with hand-computed expectations.
module tb_buffer_read_offset;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  buffer_read_offset_if bus();

  buffer_read_offset dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] sz);
    bus.load_size = 1'b1;
    bus.size_in   = sz;
    tick();
    bus.load_size = 1'b0;
    bus.size_in   = '0;
  endtask

  task automatic wr_pulse();
    bus.wr_inc = 1'b1;
    tick();
    bus.wr_inc = 1'b0;
  endtask

  task automatic rd_pulse();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load_size = 1'b0; bus.size_in = '0; bus.wr_inc = 1'b0;
    bus.rd_ready = 1'b0;  bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", bus.rd_valid); else passed++;
    total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", bus.empty); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %0b want 0", bus.full); else passed++;
    total++; if (bus.occupancy !== 32'd0) $display("FAIL reset_occ got %0d want 0", bus.occupancy); else passed++;
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL reset_offset got %0d want 0", bus.rd_offset); else passed++;
    total++; if (bus.overflow_err !== 1'b0) $display("FAIL reset_err got %0b want 0", bus.overflow_err); else passed++;
    reset = 1'b0;
    tick();
    // IDLE ignores writes until a size is loaded.
    wr_pulse();
    total++; if (bus.occupancy !== 32'd0) $display("FAIL idle_wr_ignored got %0d want 0", bus.occupancy); else passed++;
  endtask

  task automatic test_basic_fill();
    load(32'd4);
    repeat (3) wr_pulse();
    total++; if (bus.occupancy !== 32'd3) $display("FAIL fill_occ got %0d want 3", bus.occupancy); else passed++;
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL fill_rd_valid got %0b want 1", bus.rd_valid); else passed++;
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL fill_offset got %0d want 0", bus.rd_offset); else passed++;
    total++; if (bus.empty !== 1'b0) $display("FAIL fill_empty got %0b want 0", bus.empty); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL fill_full got %0b want 0", bus.full); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_off;
    load(32'd4);
    exp_off = 32'd0;
    for (int i = 0; i < 6; i++) begin
      wr_pulse();
      total++; if (bus.rd_offset !== exp_off) $display("FAIL wrap_pre_offset[%0d] got %0d want %0d", i, bus.rd_offset, exp_off); else passed++;
      total++; if (bus.rd_valid !== 1'b1) $display("FAIL wrap_rd_valid[%0d] got %0b want 1", i, bus.rd_valid); else passed++;
      rd_pulse();
      exp_off = (exp_off == 32'd3) ? 32'd0 : exp_off + 32'd1;
      total++; if (bus.rd_offset !== exp_off) $display("FAIL wrap_post_offset[%0d] got %0d want %0d", i, bus.rd_offset, exp_off); else passed++;
    end
    total++; if (bus.rd_offset !== 32'd2) $display("FAIL wrap_final_offset got %0d want 2", bus.rd_offset); else passed++;
    total++; if (bus.occupancy !== 32'd0) $display("FAIL wrap_occ got %0d want 0", bus.occupancy); else passed++;
    total++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty got %0b want 1", bus.empty); else passed++;
    // A read request while empty must not underflow.
    rd_pulse();
    total++; if (bus.occupancy !== 32'd0) $display("FAIL wrap_underflow got %0d want 0", bus.occupancy); else passed++;
  endtask

  task automatic test_overflow();
    load(32'd2);
    wr_pulse();
    wr_pulse();
    total++; if (bus.full !== 1'b1) $display("FAIL ovf_full got %0b want 1", bus.full); else passed++;
    wr_pulse();
    total++; if (bus.overflow_err !== 1'b1) $display("FAIL ovf_err got %0b want 1", bus.overflow_err); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL ovf_rd_valid got %0b want 0", bus.rd_valid); else passed++;
    total++; if (bus.occupancy !== 32'd2) $display("FAIL ovf_occ got %0d want 2", bus.occupancy); else passed++;
    bus.wr_inc = 1'b1; bus.rd_ready = 1'b1;
    tick();
    bus.wr_inc = 1'b0; bus.rd_ready = 1'b0;
    total++; if (bus.occupancy !== 32'd2) $display("FAIL err_hold_occ got %0d want 2", bus.occupancy); else passed++;
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL err_hold_offset got %0d want 0", bus.rd_offset); else passed++;
    total++; if (bus.overflow_err !== 1'b1) $display("FAIL err_hold_err got %0b want 1", bus.overflow_err); else passed++;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++; if (bus.occupancy !== 32'd0) $display("FAIL flush_occ got %0d want 0", bus.occupancy); else passed++;
    total++; if (bus.overflow_err !== 1'b0) $display("FAIL flush_err got %0b want 0", bus.overflow_err); else passed++;
    wr_pulse();
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL flush_run_rd_valid got %0b want 1", bus.rd_valid); else passed++;
    total++; if (bus.occupancy !== 32'd1) $display("FAIL flush_run_occ got %0d want 1", bus.occupancy); else passed++;
  endtask

  task automatic test_full_read_write();
    load(32'd3);
    repeat (3) wr_pulse();
    total++; if (bus.full !== 1'b1) $display("FAIL frw_full got %0b want 1", bus.full); else passed++;
    bus.wr_inc = 1'b1; bus.rd_ready = 1'b1;
    tick();
    bus.wr_inc = 1'b0; bus.rd_ready = 1'b0;
    total++; if (bus.occupancy !== 32'd3) $display("FAIL frw_occ got %0d want 3", bus.occupancy); else passed++;
    total++; if (bus.rd_offset !== 32'd1) $display("FAIL frw_offset got %0d want 1", bus.rd_offset); else passed++;
    total++; if (bus.overflow_err !== 1'b0) $display("FAIL frw_err got %0b want 0", bus.overflow_err); else passed++;
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL frw_rd_valid got %0b want 1", bus.rd_valid); else passed++;
  endtask

  task automatic test_load_priority();
    load(32'd4);
    wr_pulse();
    wr_pulse();
    total++; if (bus.occupancy !== 32'd2) $display("FAIL lp_pre_occ got %0d want 2", bus.occupancy); else passed++;
    bus.load_size = 1'b1; bus.size_in = 32'd0; bus.wr_inc = 1'b1;
    tick();
    bus.load_size = 1'b0; bus.wr_inc = 1'b0;
    total++; if (bus.occupancy !== 32'd0) $display("FAIL lp_occ got %0d want 0", bus.occupancy); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL lp_rd_valid got %0b want 0", bus.rd_valid); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL lp_full_size0 got %0b want 0", bus.full); else passed++;
    wr_pulse();
    total++; if (bus.occupancy !== 32'd0) $display("FAIL lp_idle_wr got %0d want 0", bus.occupancy); else passed++;
  endtask

  task automatic test_size_one();
    load(32'd1);
    wr_pulse();
    total++; if (bus.full !== 1'b1) $display("FAIL s1_full got %0b want 1", bus.full); else passed++;
    rd_pulse();
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL s1_offset_a got %0d want 0", bus.rd_offset); else passed++;
    wr_pulse();
    rd_pulse();
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL s1_offset_b got %0d want 0", bus.rd_offset); else passed++;
    total++; if (bus.empty !== 1'b1) $display("FAIL s1_empty got %0b want 1", bus.empty); else passed++;
  endtask

  task automatic test_reset_mid();
    load(32'd4);
    repeat (3) wr_pulse();
    rd_pulse();
    total++; if (bus.occupancy !== 32'd2) $display("FAIL rm_pre_occ got %0d want 2", bus.occupancy); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.rd_offset !== 32'd0) $display("FAIL rm_offset got %0d want 0", bus.rd_offset); else passed++;
    total++; if (bus.occupancy !== 32'd0) $display("FAIL rm_occ got %0d want 0", bus.occupancy); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL rm_rd_valid got %0b want 0", bus.rd_valid); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL rm_full got %0b want 0", bus.full); else passed++;
    #1 reset = 1'b0;
    tick();
    wr_pulse();
    total++; if (bus.occupancy !== 32'd0) $display("FAIL rm_idle_after got %0d want 0", bus.occupancy); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_fill();
    test_wrap();
    test_overflow();
    test_full_read_write();
    test_load_priority();
    test_size_one();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
